// File: rtl/output_result_buffer_pkg.sv
// Shared types and widths for the output result buffer.
package output_result_buffer_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FINISH  = 2'd3
  } drain_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              stale;
  } out_word_t;

endpackage

// File: rtl/obuf_regfile.sv
// Result storage: one synchronous write port, one registered read port.
// The read samples the array before the same-edge write lands, so a
// collision returns the old word.
module obuf_regfile
  import output_result_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Next array contents and read register; the read holds when not enabled.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
    rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  end

  // Storage and read register, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/output_result_buffer.sv
// Captures accumulation results and drains an address range to the host.
//
// state   | meaning
// IDLE    | waiting for drain_start
// FETCH   | registered read of entry[ptr] and its valid bit
// PRESENT | word on the stream, waiting for out_ready
// FINISH  | one-cycle done pulse, then back to IDLE
module output_result_buffer
  import output_result_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain_start,
  input  logic [ADDR_W-1:0] drain_base,
  input  logic [ADDR_W:0]   drain_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_stale,
  output logic              busy,
  output logic              done,
  output logic [DEPTH-1:0]  valid_map,
  output logic              overwrite_err
);

  drain_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              stale_q, stale_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              err_q, err_d;
  logic              rd_en;
  logic              clr_en;
  logic [DATA_W-1:0] rd_data;
  out_word_t         out_w;

  obuf_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (ptr_q),
    .rd_data (rd_data)
  );

  // Drain FSM: next state, pointer/remaining bookkeeping and read/clear strobes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    stale_d = stale_q;
    rd_en   = 1'b0;
    clr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (drain_start) begin
          ptr_d   = drain_base;
          rem_d   = drain_count;
          state_d = (drain_count == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        stale_d = ~valid_q[ptr_q];
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          clr_en  = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          state_d = (rem_q == (ADDR_W+1)'(1)) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Valid bits and sticky overwrite flag; a same-cycle write beats the drain clear.
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    if (clr_en) begin
      valid_d[ptr_q] = 1'b0;
    end
    if (wr_en) begin
      valid_d[wr_addr] = 1'b1;
      if (valid_q[wr_addr] && !(clr_en && (ptr_q == wr_addr))) begin
        err_d = 1'b1;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      stale_q <= 1'b0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      stale_q <= stale_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Stream word assembled from held registers so it stays stable under backpressure.
  always_comb begin
    out_w.data  = stale_q ? '0 : rd_data;
    out_w.addr  = ptr_q;
    out_w.stale = stale_q;
  end

  assign out_valid     = (state_q == ST_PRESENT);
  assign out_data      = out_w.data;
  assign out_addr      = out_w.addr;
  assign out_stale     = out_w.stale;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FINISH);
  assign valid_map     = valid_q;
  assign overwrite_err = err_q;

endmodule
